decode_ctrl_pipe: RTL and testbench
===================================

# decode_ctrl_pipe

Registered, stall- and flush-aware instruction decode stage for the pipelined RV32IM core, sitting between the IF/ID and ID/EX boundaries. Decodes opcode/funct3/funct7 into the same control fields as the single-cycle control unit, registers them as the ID/EX control bundle, and adds RV32M support: M-extension instructions launch the multiply/divide unit (MDU), and the stage holds itself and upstream for a parametrised latency. Unknown encodings produce an `illegal` flag instead of a simulation-only warning.

## Interface
- `MUL_LATENCY`, 2: cycles `busy` stays high for MUL/MULH/MULHSU/MULHU (>=1).
- `DIV_LATENCY`, 34: cycles `busy` stays high for DIV/DIVU/REM/REMU (>=1).
- `ENABLE_M`, 1: 0 makes funct7=7'h01 R-type encodings illegal and never asserts `mdu_start`/`busy`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_in` in 1: IF/ID holds a real instruction.
- `op` in 7, `funct3` in 3, `funct7` in 7: instruction fields.
- `stall_in` in 1: hazard unit stall; hold the ID/EX bundle.
- `flush` in 1: squash the instruction being captured and any in-flight MDU op.
- `valid_out` out 1: ID/EX bundle holds a real instruction.
- `PCsrc` 3, `ResultSrc` 2, `MemWrite` 1, `ALUControl` 4, `ALUsrc` 1, `ImmSrc` 3, `RegWrite` 1, `LS_mode` 3, `MemRead` 1: out, registered, same encodings as `definitions.sv`.
- `mdu_start` out 1: one-cycle launch pulse to the MDU.
- `mdu_op` out 3: funct3 of the captured M instruction.
- `mdu_kill` out 1: one-cycle abort pulse to the MDU.
- `illegal` out 1: captured instruction is an undefined encoding.
- `busy` out 1: stage occupied by an MDU op; the hazard unit stalls IF/ID on it.

## Operation
- Decode table is the base RV32I mapping: R, I-ALU, load (opcode 7'b0000011), S, B, JAL, JALR, LUI, AUIPC. M instructions (opcode 7'b0110011, funct7 7'h01) set `RegWrite`=1, `ResultSrc`=2'b11, `ALUControl`=`ALUop_ADD`, `mdu_op`=funct3.
- Illegal encodings (unknown opcode, undefined funct3/funct7 combination, or load funct3 3'b011/3'b11x, or S funct3 >2): `illegal`=1, `RegWrite`/`MemWrite`/`MemRead`=0, `PCsrc`=`NEXT_PC`.
- Bubble = `valid_out`=0, all write/read enables 0, `PCsrc`=`NEXT_PC`, `illegal`=0, other fields don't-care (drive defaults).
- Capture condition: `!stall_in && !busy_hold`, where `busy_hold` = state BUSY with count>0. On capture the bundle loads the decoded values (bubble if `!valid_in`).
- FSM states IDLE, BUSY. Counter width `$clog2(max(MUL_LATENCY,DIV_LATENCY)+1)`.
  - IDLE -> BUSY on capture of a valid M instruction: counter loads L-1 (L = MUL_LATENCY if funct3[2]=0, else DIV_LATENCY); `mdu_start`=1 next cycle.
  - BUSY: counter decrements each cycle regardless of `stall_in`; when count==0 at an edge, return to IDLE.
  - `busy` = (state==BUSY); high for exactly L cycles, first being the `mdu_start` cycle.
- Priority: `rst` > `flush` > `busy` hold > `stall_in` > capture.
- `flush`: next edge loads a bubble, FSM -> IDLE, counter cleared; if state was BUSY, `mdu_kill`=1 for the following cycle. `flush` with a valid M instruction on the inputs launches nothing.
- `stall_in` never masks `mdu_start`/`mdu_kill` once generated.

## Timing
- Reset (edge with `rst`=1): `valid_out`=0, `PCsrc`=`NEXT_PC`, `ResultSrc`=0, `MemWrite`=0, `ALUControl`=`ALUop_ADD`, `ALUsrc`=0, `ImmSrc`=`I_TYPE`, `RegWrite`=0, `LS_mode`=0, `MemRead`=0, `mdu_start`=0, `mdu_op`=0, `mdu_kill`=0, `illegal`=0, `busy`=0, state IDLE, counter 0. Reset mid-BUSY aborts without `mdu_kill`.
- Decode latency: inputs at edge k appear on outputs after edge k, i.e. one cycle.
- `mdu_start` pulse cycle coincides with the first cycle `valid_out`=1 for the M instruction; `busy` drops in cycle start+L; the next instruction is captured at the edge ending the last `busy` cycle (if `stall_in`=0).
- L=1: `busy` high one cycle only; no throughput loss beyond that cycle.
- Back-to-back M instructions: second launches the cycle after `busy` drops; no overlap.

## Test plan
- Reset then `valid_in`=1, op=0110011, funct3=000, funct7=20 -> after one edge `valid_out`=1, `ALUControl`=`ALUop_SUB`, `RegWrite`=1, `busy`=0.
- MUL (funct7=01, funct3=000), MUL_LATENCY=2 -> `mdu_start` one cycle, `mdu_op`=000, `ResultSrc`=11, `busy` high exactly 2 cycles; next ADDI captured the edge `busy` falls.
- DIV (funct3=100), DIV_LATENCY=34, `flush` asserted in 5th busy cycle -> `busy`=0 and `valid_out`=0 next cycle, `mdu_kill` one-cycle pulse, counter 0.
- `stall_in`=1 for 3 cycles with LW held -> bundle unchanged (`MemRead`=1, `LS_mode`=`W_MODE`), `valid_out` stays 1; op=0000000 captured after -> `illegal`=1, all write enables 0.
- ENABLE_M=0, MUL encoding -> `illegal`=1, `mdu_start`=0, `busy`=0; `rst` asserted during a DIV busy window -> all outputs at reset values next cycle, no `mdu_kill`.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// Registered ID/EX decode stage for the RV32IM pipeline: base RV32I control decode,
// illegal-encoding flag, and a small FSM that launches and holds for the multiply/divide unit.
module decode_ctrl_pipe #(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 34,
  parameter bit ENABLE_M    = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid_in,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic       i_stall_in,
  input  logic       i_flush,
  output logic       o_valid_out,
  output logic [2:0] o_PCsrc,
  output logic [1:0] o_ResultSrc,
  output logic       o_MemWrite,
  output logic [3:0] o_ALUControl,
  output logic       o_ALUsrc,
  output logic [2:0] o_ImmSrc,
  output logic       o_RegWrite,
  output logic [2:0] o_LS_mode,
  output logic       o_MemRead,
  output logic       o_mdu_start,
  output logic [2:0] o_mdu_op,
  output logic       o_mdu_kill,
  output logic       o_illegal,
  output logic       o_busy
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] NEXT_PC = 3'd0;
  localparam logic [2:0] JAL_PC  = 3'd1;
  localparam logic [2:0] JALR_PC = 3'd2;
  localparam logic [2:0] BEQ_PC  = 3'd3;
  localparam logic [2:0] BNE_PC  = 3'd4;
  localparam logic [2:0] BLT_PC  = 3'd5;
  localparam logic [2:0] BGE_PC  = 3'd6;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_MDU = 2'b11;

  localparam logic [3:0] ALUop_ADD   = 4'd0;
  localparam logic [3:0] ALUop_SUB   = 4'd1;
  localparam logic [3:0] ALUop_AND   = 4'd2;
  localparam logic [3:0] ALUop_OR    = 4'd3;
  localparam logic [3:0] ALUop_XOR   = 4'd4;
  localparam logic [3:0] ALUop_SLL   = 4'd5;
  localparam logic [3:0] ALUop_SRL   = 4'd6;
  localparam logic [3:0] ALUop_SRA   = 4'd7;
  localparam logic [3:0] ALUop_SLT   = 4'd8;
  localparam logic [3:0] ALUop_SLTU  = 4'd9;
  localparam logic [3:0] ALUop_LUI   = 4'd10;
  localparam logic [3:0] ALUop_AUIPC = 4'd11;

  localparam logic [2:0] I_TYPE = 3'd0;
  localparam logic [2:0] S_TYPE = 3'd1;
  localparam logic [2:0] B_TYPE = 3'd2;
  localparam logic [2:0] J_TYPE = 3'd3;
  localparam logic [2:0] U_TYPE = 3'd4;

  localparam int MAXL = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CW   = $clog2(MAXL + 1);
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_LATENCY - 1);

  typedef struct packed {
    logic       valid;
    logic [2:0] pcsrc;
    logic [1:0] res;
    logic       mw;
    logic [3:0] alu;
    logic       alusrc;
    logic [2:0] imm;
    logic       rw;
    logic [2:0] ls;
    logic       mr;
    logic       ill;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '{valid: 1'b0, pcsrc: NEXT_PC, res: RES_ALU, mw: 1'b0,
                               alu: ALUop_ADD, alusrc: 1'b0, imm: I_TYPE, rw: 1'b0,
                               ls: 3'd0, mr: 1'b0, ill: 1'b0};

  typedef enum logic {IDLE, BUSY} state_t;

  ctrl_t          r_ctrl;
  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_mdu_start;
  logic           r_mdu_kill;
  logic [2:0]     r_mdu_op;

  ctrl_t          w_dec;
  logic           w_is_m;
  logic           w_bad;
  logic           w_busy_hold;
  logic           w_capture;

  function automatic logic [3:0] alu_f3(input logic [2:0] f);
    case (f)
      3'b000:  alu_f3 = ALUop_ADD;
      3'b001:  alu_f3 = ALUop_SLL;
      3'b010:  alu_f3 = ALUop_SLT;
      3'b011:  alu_f3 = ALUop_SLTU;
      3'b100:  alu_f3 = ALUop_XOR;
      3'b101:  alu_f3 = ALUop_SRL;
      3'b110:  alu_f3 = ALUop_OR;
      default: alu_f3 = ALUop_AND;
    endcase
  endfunction

  always_comb begin
    w_dec  = BUBBLE;
    w_is_m = 1'b0;
    w_bad  = 1'b0;
    case (i_op)
      OP_R: begin
        w_dec.rw = 1'b1;
        case (i_funct7)
          7'h00: w_dec.alu = alu_f3(i_funct3);
          7'h20: begin
            if (i_funct3 == 3'b000)      w_dec.alu = ALUop_SUB;
            else if (i_funct3 == 3'b101) w_dec.alu = ALUop_SRA;
            else                         w_bad = 1'b1;
          end
          7'h01: begin
            if (ENABLE_M) begin
              w_is_m    = 1'b1;
              w_dec.res = RES_MDU;
            end else begin
              w_bad = 1'b1;
            end
          end
          default: w_bad = 1'b1;
        endcase
      end
      OP_I: begin
        w_dec.rw     = 1'b1;
        w_dec.alusrc = 1'b1;
        w_dec.alu    = alu_f3(i_funct3);
        // Shift-immediates carry funct7 in imm[11:5]; only 0x00 / 0x20 (right shifts) are defined.
        if (i_funct3 == 3'b001 && i_funct7 != 7'h00) w_bad = 1'b1;
        if (i_funct3 == 3'b101) begin
          if (i_funct7 == 7'h20)      w_dec.alu = ALUop_SRA;
          else if (i_funct7 != 7'h00) w_bad = 1'b1;
        end
      end
      OP_LOAD: begin
        w_dec.rw     = 1'b1;
        w_dec.mr     = 1'b1;
        w_dec.res    = RES_MEM;
        w_dec.alusrc = 1'b1;
        w_dec.ls     = i_funct3;
        if (i_funct3 == 3'b011 || i_funct3[2:1] == 2'b11) w_bad = 1'b1;
      end
      OP_STORE: begin
        w_dec.mw     = 1'b1;
        w_dec.alusrc = 1'b1;
        w_dec.imm    = S_TYPE;
        w_dec.ls     = i_funct3;
        if (i_funct3 > 3'd2) w_bad = 1'b1;
      end
      OP_BR: begin
        w_dec.imm = B_TYPE;
        case (i_funct3)
          3'b000: begin w_dec.pcsrc = BEQ_PC; w_dec.alu = ALUop_SUB;  end
          3'b001: begin w_dec.pcsrc = BNE_PC; w_dec.alu = ALUop_SUB;  end
          3'b100: begin w_dec.pcsrc = BLT_PC; w_dec.alu = ALUop_SLT;  end
          3'b101: begin w_dec.pcsrc = BGE_PC; w_dec.alu = ALUop_SLT;  end
          3'b110: begin w_dec.pcsrc = BLT_PC; w_dec.alu = ALUop_SLTU; end
          3'b111: begin w_dec.pcsrc = BGE_PC; w_dec.alu = ALUop_SLTU; end
          default: w_bad = 1'b1;
        endcase
      end
      OP_JAL: begin
        w_dec.pcsrc = JAL_PC;
        w_dec.rw    = 1'b1;
        w_dec.res   = RES_PC4;
        w_dec.imm   = J_TYPE;
      end
      OP_JALR: begin
        w_dec.pcsrc  = JALR_PC;
        w_dec.rw     = 1'b1;
        w_dec.res    = RES_PC4;
        w_dec.alusrc = 1'b1;
        if (i_funct3 != 3'b000) w_bad = 1'b1;
      end
      OP_LUI: begin
        w_dec.rw     = 1'b1;
        w_dec.alusrc = 1'b1;
        w_dec.imm    = U_TYPE;
        w_dec.alu    = ALUop_LUI;
      end
      OP_AUIPC: begin
        w_dec.rw     = 1'b1;
        w_dec.alusrc = 1'b1;
        w_dec.imm    = U_TYPE;
        w_dec.alu    = ALUop_AUIPC;
      end
      default: w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_dec     = BUBBLE;
      w_dec.ill = 1'b1;
      w_is_m    = 1'b0;
    end
    if (!i_valid_in) begin
      w_dec  = BUBBLE;
      w_is_m = 1'b0;
    end else begin
      w_dec.valid = 1'b1;
    end
  end

  assign w_busy_hold = (r_state == BUSY) && (r_cnt != '0);
  assign w_capture   = !i_stall_in && !w_busy_hold;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ctrl      <= BUBBLE;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mdu_start <= 1'b0;
      r_mdu_kill  <= 1'b0;
      r_mdu_op    <= 3'd0;
    end else begin
      r_mdu_start <= 1'b0;
      r_mdu_kill  <= 1'b0;
      if (i_flush) begin
        r_ctrl     <= BUBBLE;
        r_state    <= IDLE;
        r_cnt      <= '0;
        r_mdu_kill <= (r_state == BUSY);
      end else begin
        // The MDU runs on its own clock budget, so the countdown ignores stall_in.
        if (r_state == BUSY) begin
          if (r_cnt == '0) r_state <= IDLE;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        if (w_capture) begin
          r_ctrl <= w_dec;
          if (w_is_m) begin
            r_state     <= BUSY;
            r_cnt       <= i_funct3[2] ? DIV_LD : MUL_LD;
            r_mdu_start <= 1'b1;
            r_mdu_op    <= i_funct3;
          end
        end
      end
    end
  end

  assign o_valid_out  = r_ctrl.valid;
  assign o_PCsrc      = r_ctrl.pcsrc;
  assign o_ResultSrc  = r_ctrl.res;
  assign o_MemWrite   = r_ctrl.mw;
  assign o_ALUControl = r_ctrl.alu;
  assign o_ALUsrc     = r_ctrl.alusrc;
  assign o_ImmSrc     = r_ctrl.imm;
  assign o_RegWrite   = r_ctrl.rw;
  assign o_LS_mode    = r_ctrl.ls;
  assign o_MemRead    = r_ctrl.mr;
  assign o_illegal    = r_ctrl.ill;
  assign o_mdu_start  = r_mdu_start;
  assign o_mdu_kill   = r_mdu_kill;
  assign o_mdu_op     = r_mdu_op;
  assign o_busy       = (r_state == BUSY);

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: decode vectors, MDU launch/hold, flush, stall, reset.
module tb_decode_ctrl_pipe;
  logic clk = 1'b0;
  logic rst, vin, stall, flush;
  logic [6:0] op, f7;
  logic [2:0] f3;

  logic       valid_out, mw, alusrc, rw, mr, start, kill, ill, busy;
  logic [2:0] pcsrc, imm, ls, mop;
  logic [1:0] res;
  logic [3:0] alu;

  logic       n_valid_out, n_mw, n_alusrc, n_rw, n_mr, n_start, n_kill, n_ill, n_busy;
  logic [2:0] n_pcsrc, n_imm, n_ls, n_mop;
  logic [1:0] n_res;
  logic [3:0] n_alu;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_ctrl_pipe dut (
    .i_clk(clk), .i_rst(rst), .i_valid_in(vin), .i_op(op), .i_funct3(f3), .i_funct7(f7),
    .i_stall_in(stall), .i_flush(flush),
    .o_valid_out(valid_out), .o_PCsrc(pcsrc), .o_ResultSrc(res), .o_MemWrite(mw),
    .o_ALUControl(alu), .o_ALUsrc(alusrc), .o_ImmSrc(imm), .o_RegWrite(rw), .o_LS_mode(ls),
    .o_MemRead(mr), .o_mdu_start(start), .o_mdu_op(mop), .o_mdu_kill(kill),
    .o_illegal(ill), .o_busy(busy)
  );

  decode_ctrl_pipe #(.ENABLE_M(1'b0)) dut_nm (
    .i_clk(clk), .i_rst(rst), .i_valid_in(vin), .i_op(op), .i_funct3(f3), .i_funct7(f7),
    .i_stall_in(stall), .i_flush(flush),
    .o_valid_out(n_valid_out), .o_PCsrc(n_pcsrc), .o_ResultSrc(n_res), .o_MemWrite(n_mw),
    .o_ALUControl(n_alu), .o_ALUsrc(n_alusrc), .o_ImmSrc(n_imm), .o_RegWrite(n_rw),
    .o_LS_mode(n_ls), .o_MemRead(n_mr), .o_mdu_start(n_start), .o_mdu_op(n_mop),
    .o_mdu_kill(n_kill), .o_illegal(n_ill), .o_busy(n_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic [6:0] s7);
    vin = 1'b1; op = o; f3 = f; f7 = s7;
  endtask

  task automatic chk_bundle(input string tag, input logic [2:0] e_pc, input logic [1:0] e_res,
                            input logic [3:0] e_alu, input logic e_src, input logic [2:0] e_imm,
                            input logic e_rw, input logic e_mw, input logic e_mr, input logic e_ill);
    chk({tag, ".valid"}, valid_out, 1);
    chk({tag, ".pc"},    pcsrc,     e_pc);
    chk({tag, ".res"},   res,       e_res);
    chk({tag, ".alu"},   alu,       e_alu);
    chk({tag, ".src"},   alusrc,    e_src);
    chk({tag, ".imm"},   imm,       e_imm);
    chk({tag, ".rw"},    rw,        e_rw);
    chk({tag, ".mw"},    mw,        e_mw);
    chk({tag, ".mr"},    mr,        e_mr);
    chk({tag, ".ill"},   ill,       e_ill);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, valid_out, 0);
    chk({tag, ".pc"},    pcsrc, 0);
    chk({tag, ".res"},   res, 0);
    chk({tag, ".mw"},    mw, 0);
    chk({tag, ".alu"},   alu, 0);
    chk({tag, ".src"},   alusrc, 0);
    chk({tag, ".imm"},   imm, 0);
    chk({tag, ".rw"},    rw, 0);
    chk({tag, ".ls"},    ls, 0);
    chk({tag, ".mr"},    mr, 0);
    chk({tag, ".start"}, start, 0);
    chk({tag, ".mop"},   mop, 0);
    chk({tag, ".kill"},  kill, 0);
    chk({tag, ".ill"},   ill, 0);
    chk({tag, ".busy"},  busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d", total);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; vin = 1'b0; stall = 1'b0; flush = 1'b0;
    op = 7'd0; f3 = 3'd0; f7 = 7'd0;
    step;
    chk_reset("rst");
    chk("rst.nm_busy", n_busy, 0);
    rst = 1'b0;

    // SUB
    drive(7'b0110011, 3'b000, 7'h20); step;
    chk_bundle("sub", 3'd0, 2'b00, 4'd1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sub.busy", busy, 0);

    // MUL, latency 2, ADDI waiting behind it
    drive(7'b0110011, 3'b000, 7'h01); step;
    chk("mul.start", start, 1);
    chk("mul.mop",   mop, 0);
    chk("mul.res",   res, 3);
    chk("mul.alu",   alu, 0);
    chk("mul.rw",    rw, 1);
    chk("mul.busy1", busy, 1);
    chk("mul.valid", valid_out, 1);
    chk("nm.ill",    n_ill, 1);
    chk("nm.start",  n_start, 0);
    chk("nm.busy",   n_busy, 0);
    chk("nm.rw",     n_rw, 0);
    drive(7'b0010011, 3'b000, 7'h00); step;
    chk("mul.start2", start, 0);
    chk("mul.busy2",  busy, 1);
    chk("mul.held",   res, 3);
    step;
    chk("mul.busy3", busy, 0);
    chk_bundle("addi", 3'd0, 2'b00, 4'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // DIV flushed in its 5th busy cycle
    drive(7'b0110011, 3'b100, 7'h01); step;
    chk("div.start", start, 1);
    chk("div.mop",   mop, 4);
    chk("div.busy1", busy, 1);
    vin = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      step;
      chk($sformatf("div.busy%0d", i), busy, 1);
    end
    flush = 1'b1; step;
    chk("flush.busy",  busy, 0);
    chk("flush.valid", valid_out, 0);
    chk("flush.kill",  kill, 1);
    chk("flush.rw",    rw, 0);
    flush = 1'b0; step;
    chk("flush.kill2", kill, 0);
    chk("flush.busy2", busy, 0);

    // flush with an M instruction on the inputs launches nothing
    drive(7'b0110011, 3'b000, 7'h01); flush = 1'b1; step;
    chk("flm.start", start, 0);
    chk("flm.busy",  busy, 0);
    chk("flm.valid", valid_out, 0);
    chk("flm.kill",  kill, 0);
    flush = 1'b0;

    // LW held under a 3-cycle stall, then an illegal opcode
    drive(7'b0000011, 3'b010, 7'h00); step;
    chk_bundle("lw", 3'd0, 2'b01, 4'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("lw.ls", ls, 2);
    stall = 1'b1;
    drive(7'b0000000, 3'b000, 7'h00);
    for (int i = 0; i < 3; i++) begin
      step;
      chk($sformatf("stall%0d.mr", i), mr, 1);
      chk($sformatf("stall%0d.ls", i), ls, 2);
      chk($sformatf("stall%0d.valid", i), valid_out, 1);
    end
    stall = 1'b0; step;
    chk_bundle("op0", 3'd0, 2'b00, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // assorted decode vectors
    drive(7'b0100011, 3'b010, 7'h00); step;
    chk_bundle("sw", 3'd0, 2'b00, 4'd0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sw.ls", ls, 2);
    drive(7'b0100011, 3'b011, 7'h00); step;
    chk_bundle("s011", 3'd0, 2'b00, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(7'b0000011, 3'b011, 7'h00); step;
    chk_bundle("ld011", 3'd0, 2'b00, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(7'b0000011, 3'b110, 7'h00); step;
    chk("ld110.ill", ill, 1);
    chk("ld110.mr",  mr, 0);
    drive(7'b0000011, 3'b100, 7'h00); step;
    chk("lbu.ls", ls, 4);
    chk("lbu.ill", ill, 0);
    drive(7'b1101111, 3'b000, 7'h00); step;
    chk_bundle("jal", 3'd1, 2'b10, 4'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(7'b1100111, 3'b000, 7'h00); step;
    chk_bundle("jalr", 3'd2, 2'b10, 4'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(7'b1100011, 3'b001, 7'h00); step;
    chk_bundle("bne", 3'd4, 2'b00, 4'd1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(7'b1100011, 3'b110, 7'h00); step;
    chk_bundle("bltu", 3'd5, 2'b00, 4'd9, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(7'b1100011, 3'b010, 7'h00); step;
    chk("b010.ill", ill, 1);
    drive(7'b0110111, 3'b000, 7'h00); step;
    chk_bundle("lui", 3'd0, 2'b00, 4'd10, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(7'b0010111, 3'b000, 7'h00); step;
    chk_bundle("auipc", 3'd0, 2'b00, 4'd11, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(7'b0010011, 3'b101, 7'h20); step;
    chk_bundle("srai", 3'd0, 2'b00, 4'd7, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(7'b0010011, 3'b001, 7'h20); step;
    chk("slli20.ill", ill, 1);
    drive(7'b0110011, 3'b001, 7'h20); step;
    chk("r20_001.ill", ill, 1);
    drive(7'b0110011, 3'b111, 7'h00); step;
    chk("and.alu", alu, 2);
    vin = 1'b0; step;
    chk("bubble.valid", valid_out, 0);
    chk("bubble.ill",   ill, 0);
    chk("bubble.rw",    rw, 0);

    // MUL under stall: countdown continues, start not masked
    drive(7'b0110011, 3'b011, 7'h01); step;
    chk("mstall.start", start, 1);
    chk("mstall.mop",   mop, 3);
    stall = 1'b1; vin = 1'b0; step;
    chk("mstall.busy2", busy, 1);
    step;
    chk("mstall.busy3", busy, 0);
    chk("mstall.held",  res, 3);
    stall = 1'b0;

    // reset in a DIV busy window
    drive(7'b0110011, 3'b101, 7'h01); step;
    chk("rdiv.start", start, 1);
    vin = 1'b0; step;
    chk("rdiv.busy", busy, 1);
    rst = 1'b1; step;
    chk_reset("rdiv");
    rst = 1'b0; step;
    chk("rdiv.kill2", kill, 0);
    chk("rdiv.busy2", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
